// File: rtl/iobus_arbiter.sv
// iobus_arbiter: round-robin arbiter that shares one IOBUS between the
// pipeline memory stage (requester 0) and the DMA/debug port (requester 1).
// Each access is IDLE -> WAIT -> RESP. The bus drive is registered. A wait-state
// counter aborts accesses whose peripheral never raises IOBUS_READY.
module iobus_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ_0,
  input  logic        WR_0,
  input  logic [31:0] ADDR_0,
  input  logic [31:0] WDATA_0,
  input  logic        REQ_1,
  input  logic        WR_1,
  input  logic [31:0] ADDR_1,
  input  logic [31:0] WDATA_1,
  output logic        ACK_0,
  output logic        ACK_1,
  output logic        ERR,
  output logic [31:0] RDATA,
  output logic        STALL_0,
  output logic [31:0] IOBUS_ADDR,
  output logic [31:0] IOBUS_OUT,
  output logic        IOBUS_WR,
  output logic        IOBUS_RD,
  input  logic [31:0] IOBUS_IN,
  input  logic        IOBUS_READY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Last wait cycle index. The counter is compared before it increments, so it never wraps.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        last_gnt_q, last_gnt_d;
  logic        gnt_q, gnt_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [31:0] rdata_q, rdata_d;
  logic        gnt_sel;

  // This block holds the state register and the registered bus drive. Reset is synchronous,
  // so an access in flight is dropped at the next edge and never acknowledged.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      rdata_q    <= rdata_d;
    end
  end

  // This block picks the winner when both requesters ask at once: the side that did not win last time.
  always_comb begin
    gnt_sel = 1'b0;
    if (REQ_0 && REQ_1) begin
      gnt_sel = ~last_gnt_q;
    end else if (REQ_1) begin
      gnt_sel = 1'b1;
    end
  end

  // This block computes the next state. It grants in IDLE and waits for READY or the timeout.
  // It then acknowledges in RESP.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    rdata_d    = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (REQ_0 || REQ_1) begin
          gnt_d   = gnt_sel;
          addr_d  = gnt_sel ? ADDR_1 : ADDR_0;
          wdata_d = gnt_sel ? WDATA_1 : WDATA_0;
          wr_d    = gnt_sel ? WR_1 : WR_0;
          rd_d    = gnt_sel ? ~WR_1 : ~WR_0;
          cnt_d   = 8'd0;
          err_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (IOBUS_READY) begin
          wr_d    = 1'b0;
          rd_d    = 1'b0;
          if (rd_q) begin
            rdata_d = IOBUS_IN;
          end
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          wr_d    = 1'b0;
          rd_d    = 1'b0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        last_gnt_d = gnt_q;
        err_d      = 1'b0;
        rdata_d    = 32'd0;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // This block decodes the responses from RESP. STALL_0 stays combinational so the pipeline
  // releases in the same cycle as the ACK.
  always_comb begin
    ACK_0      = (state_q == ST_RESP) && !gnt_q;
    ACK_1      = (state_q == ST_RESP) && gnt_q;
    ERR        = (state_q == ST_RESP) && err_q;
    RDATA      = rdata_q;
    STALL_0    = REQ_0 && !ACK_0;
    IOBUS_ADDR = addr_q;
    IOBUS_OUT  = wdata_q;
    IOBUS_WR   = wr_q;
    IOBUS_RD   = rd_q;
  end

endmodule
